adc_meas_ctrl: RTL and testbench
================================

// Module: adc_meas_ctrl
// PURPOSE
//  Measurement sequencer between the 8-bit parallel ADC and the 6-digit 595 display driver of the voltmeter.
//  Generates ad_clk, calibrates the zero-volt code at start-up or on request, then repeatedly averages sample
//  windows and converts each to a signed millivolt magnitude (volt + sign) at a controlled update rate.
//  Outputs feed the display data/sign inputs directly; volt_vld marks each new reading.
// PARAMETERS
//  CLK_DIV   25      ad_clk half-period in sys_clk cycles (>=2); period = 2*CLK_DIV
//  CAL_LOG2  10      log2 of samples averaged for zero calibration (1..12)
//  AVG_LOG2  4       log2 of samples averaged per reading (1..8)
//  K_POS     322520  positive-side scale, mV/LSB * 8192 (5000/127), 20 bits
//  K_NEG     320000  negative-side scale, mV/LSB * 8192 (5000/128), 20 bits
//  VMAX      9999    saturation limit for volt
// PORTS
//  sys_clk    in   1   system clock
//  sys_rst_n  in   1   asynchronous active-low reset
//  ad_data    in   8   ADC output code
//  recal      in   1   level; restart zero calibration
//  hold       in   1   level; freeze displayed reading
//  ad_clk     out  1   ADC conversion clock
//  volt       out  16  |voltage| in mV, binary, 0..VMAX
//  sign       out  1   1 = negative reading
//  volt_vld   out  1   one-cycle pulse when volt/sign update
//  cal_done   out  1   high once a valid zero code is held
// BEHAVIOUR
//  Reset: ad_clk=0, volt=0, sign=0, volt_vld=0, cal_done=0, zero=128, accumulators/counters 0, state CAL.
//  Clocking: div_cnt 0..CLK_DIV-1; ad_clk toggles when div_cnt==CLK_DIV-1. smp_en=1 for one cycle when
//   div_cnt==CLK_DIV-1 && ad_clk==1 (falling toggle); ad_data captured that cycle. ad_clk runs in all states.
//  FSM CAL -> RUN -> CONV -> UPD -> RUN:
//   CAL: each smp_en adds sample to acc, increments cnt. On sample 2^CAL_LOG2: zero<=(acc+sample)>>CAL_LOG2
//    (truncate), cal_done<=1, acc/cnt cleared, -> RUN.
//   RUN: same accumulation over 2^AVG_LOG2 samples; on last: avg<=(acc+sample)>>AVG_LOG2, -> CONV.
//   CONV (1 cycle): diff=avg-zero (9-bit signed). diff<0: neg=1, mag=-diff, K=K_NEG; else neg=0, mag=diff,
//    K=K_POS. mv=(mag*K)>>13 (28-bit product, truncate); mv>VMAX -> VMAX. -> UPD.
//   UPD (1 cycle): hold=0: volt<=mv, sign<=neg&&(mv!=0) (no "-0"), volt_vld<=1 next cycle. hold=1: outputs
//    and volt_vld unchanged/0. -> RUN, acc/cnt cleared.
//  smp_en during CONV/UPD: sample dropped (not counted).
//  Latency: volt_vld asserts 3 sys_clk after the last window sample's smp_en cycle.
//  recal=1 in any state: next state CAL, acc/cnt cleared, cal_done<=0; volt/sign hold last values; no
//   volt_vld until calibration and a full window complete. recal held high keeps FSM in CAL with cnt=0.
//  recal and last-sample smp_en in same cycle: recal wins, sample discarded.
//  hold does not stop sampling; reading after release reflects the window in progress, never a stale one.
//  Reset mid-operation: immediate return to reset values; zero reverts to 128.
// TESTING (CLK_DIV=2, CAL_LOG2=4, AVG_LOG2=2 unless noted)
//  1 ad_data=128 from reset -> ad_clk period 4 cycles; cal_done rises after 16th sample; first volt_vld
//    after 4 more samples with volt=0, sign=0; repeats every 4 samples.
//  2 cal at 128, then ad_data=255 -> volt=5000 sign=0; ad_data=0 -> volt=5000 sign=1; ad_data=129 ->
//    volt=39 sign=0; ad_data=127 -> volt=39 sign=1.
//  3 K_POS=1048575, cal at 128, ad_data=255 -> volt saturates at 9999, sign=0; ad_data alternating 128/129
//    in window -> avg 128, volt=0, sign=0.
//  4 hold=1 while ad_data steps 128->200 -> no volt_vld, volt stays 0; release hold -> next volt_vld shows
//    (72*322520)>>13 = 2834.
//  5 recal pulse mid-window with ad_data=100 -> cal_done=0 next cycle, volt/sign held; after 16 samples
//    cal_done=1, zero=100; next reading volt=0; recal coinciding with 16th cal sample -> cal restarts.
//  6 sys_rst_n low mid-RUN -> all outputs reset values same cycle (async); after release full cal repeats.

Source files
------------

// File: rtl/adc_meas_ctrl.sv
// rtl/adc_meas_ctrl.sv - ADC clocking, zero calibration, window averaging and millivolt conversion
module adc_meas_ctrl #(
  parameter int CLK_DIV  = 25,
  parameter int CAL_LOG2 = 10,
  parameter int AVG_LOG2 = 4,
  parameter int K_POS    = 322520,
  parameter int K_NEG    = 320000,
  parameter int VMAX     = 9999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  ad_data,
  input  logic        recal,
  input  logic        hold,
  output logic        ad_clk,
  output logic [15:0] volt,
  output logic        sign,
  output logic        volt_vld,
  output logic        cal_done
);

  localparam int MAX_LOG2 = (CAL_LOG2 > AVG_LOG2) ? CAL_LOG2 : AVG_LOG2;
  localparam int ACC_W    = 8 + MAX_LOG2;
  localparam int CNT_W    = MAX_LOG2;
  localparam int DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'((1 << CAL_LOG2) - 1);
  localparam logic [CNT_W-1:0] AVG_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [27:0]      K_POS_W  = 28'(K_POS);
  localparam logic [27:0]      K_NEG_W  = 28'(K_NEG);
  localparam logic [15:0]      VMAX_W   = 16'(VMAX);

  typedef enum logic [1:0] {ST_CAL, ST_RUN, ST_CONV, ST_UPD} state_t;
  state_t state, state_nxt;

  logic [DIV_W-1:0] div_cnt;
  logic             smp_en;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       zero;
  logic [7:0]       avg;
  logic             cal_last;
  logic             run_last;
  logic signed [8:0] diff;
  logic             neg;
  logic             neg_r;
  logic [8:0]       mag;
  logic [27:0]      prod;
  logic [15:0]      mv;
  logic [15:0]      mv_r;

  // ad_clk free-runs; a sample is taken on its falling toggle
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
      ad_clk  <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      ad_clk  <= ~ad_clk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign smp_en   = (div_cnt == DIV_LAST) && ad_clk;
  assign acc_sum  = acc + ACC_W'(ad_data);
  assign cal_last = smp_en && (state == ST_CAL) && (cnt == CAL_LAST);
  assign run_last = smp_en && (state == ST_RUN) && (cnt == AVG_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_CAL;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CAL:  if (cal_last) state_nxt = ST_RUN;
      ST_RUN:  if (run_last) state_nxt = ST_CONV;
      ST_CONV: state_nxt = ST_UPD;
      ST_UPD:  state_nxt = ST_RUN;
      default: state_nxt = ST_CAL;
    endcase
    if (recal) state_nxt = ST_CAL;
  end

  // Asymmetric scale: full positive swing is 127 codes, full negative swing is 128
  always_comb begin
    diff = $signed({1'b0, avg}) - $signed({1'b0, zero});
    neg  = diff[8];
    mag  = neg ? $unsigned(-diff) : $unsigned(diff);
    prod = 28'(mag) * (neg ? K_NEG_W : K_POS_W);
    mv   = 16'(prod >> 13);
    if (mv > VMAX_W) mv = VMAX_W;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      zero     <= 8'd128;
      avg      <= '0;
      mv_r     <= '0;
      neg_r    <= 1'b0;
      volt     <= '0;
      sign     <= 1'b0;
      volt_vld <= 1'b0;
      cal_done <= 1'b0;
    end else begin
      volt_vld <= 1'b0;
      if (recal) begin
        acc      <= '0;
        cnt      <= '0;
        cal_done <= 1'b0;
      end else begin
        case (state)
          ST_CAL, ST_RUN: begin
            if (cal_last) begin
              zero     <= 8'(acc_sum >> CAL_LOG2);
              cal_done <= 1'b1;
              acc      <= '0;
              cnt      <= '0;
            end else if (run_last) begin
              avg <= 8'(acc_sum >> AVG_LOG2);
              acc <= '0;
              cnt <= '0;
            end else if (smp_en) begin
              acc <= acc_sum;
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_CONV: begin
            mv_r  <= mv;
            neg_r <= neg;
          end
          ST_UPD: begin
            acc <= '0;
            cnt <= '0;
            if (!hold) begin
              volt     <= mv_r;
              sign     <= neg_r && (mv_r != 16'd0);
              volt_vld <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_meas_ctrl.sv
// tb/tb_adc_meas_ctrl.sv - randomized model-checked bench for adc_meas_ctrl
module tb_adc_meas_ctrl;

  localparam int CD    = 2;
  localparam int PER   = 2 * CD;
  localparam int CAL_N = 16;
  localparam int AVG_N = 4;
  localparam int K_SAT = 1048575;
  localparam int LIMIT = 600;

  typedef struct {
    logic [15:0] v;
    logic        s;
    logic [15:0] vs;
    logic        ss;
    int          e;
  } rd_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  ad_data = 8'd128;
  logic        recal = 1'b0;
  logic        hold = 1'b0;
  logic        ad_clk, sign, volt_vld, cal_done;
  logic [15:0] volt;
  logic        ad_clk_s, sign_s, volt_vld_s, cal_done_s;
  logic [15:0] volt_s;

  int checks = 0;
  int errors = 0;

  int  edge_cnt, m_edge, pend_edge, m_zero, m_avg;
  bit  m_cal, pend;
  int  win[$];
  rd_t pend_rd, mon;
  rd_t exp_q[$];
  rd_t obs_q[$];

  adc_meas_ctrl #(.CLK_DIV(CD), .CAL_LOG2(4), .AVG_LOG2(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ad_data(ad_data), .recal(recal), .hold(hold),
    .ad_clk(ad_clk), .volt(volt), .sign(sign), .volt_vld(volt_vld), .cal_done(cal_done)
  );

  adc_meas_ctrl #(.CLK_DIV(CD), .CAL_LOG2(4), .AVG_LOG2(2), .K_POS(K_SAT)) dut_sat (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ad_data(ad_data), .recal(recal), .hold(hold),
    .ad_clk(ad_clk_s), .volt(volt_s), .sign(sign_s), .volt_vld(volt_vld_s), .cal_done(cal_done_s)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic void conv(input int avg, input int z, input longint kp,
                               output logic [15:0] mv, output logic s);
    longint d, m;
    d = longint'(avg - z);
    if (d < 0) m = (-d) * 320000 / 8192;
    else       m = d * kp / 8192;
    if (m > 9999) m = 9999;
    mv = 16'(m);
    s  = (d < 0) && (m != 0);
  endfunction

  function automatic bit rd_eq(input rd_t a, input rd_t b);
    return (a.v === b.v) && (a.s === b.s) && (a.vs === b.vs) && (a.ss === b.ss) && (a.e == b.e);
  endfunction

  function automatic string rd_str(input rd_t a);
    return $sformatf("v=%0d s=%0d vs=%0d ss=%0d edge=%0d", a.v, a.s, a.vs, a.ss, a.e);
  endfunction

  // Reference: every PER-th edge is a sample; 16 samples set zero, then each 4-sample window is one reading
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      edge_cnt = 0;
      m_cal    = 1'b0;
      m_zero   = 128;
      pend     = 1'b0;
      win.delete();
    end else begin
      m_edge = edge_cnt;
      edge_cnt++;
      if (recal) begin
        m_cal = 1'b0;
        pend  = 1'b0;
        win.delete();
      end else begin
        if (pend && m_edge == pend_edge) begin
          pend = 1'b0;
          if (!hold) begin
            pend_rd.e = m_edge;
            exp_q.push_back(pend_rd);
          end
        end
        if (m_edge % PER == PER - 1) begin
          win.push_back(int'(ad_data));
          if (!m_cal && win.size() == CAL_N) begin
            m_zero = win.sum() / CAL_N;
            m_cal  = 1'b1;
            win.delete();
          end else if (m_cal && win.size() == AVG_N) begin
            m_avg = win.sum() / AVG_N;
            conv(m_avg, m_zero, 322520, pend_rd.v, pend_rd.s);
            conv(m_avg, m_zero, K_SAT, pend_rd.vs, pend_rd.ss);
            pend      = 1'b1;
            pend_edge = m_edge + 2;
            win.delete();
          end
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    if (sys_rst_n && volt_vld === 1'b1) begin
      mon.v  = volt;
      mon.s  = sign;
      mon.vs = volt_s;
      mon.ss = sign_s;
      mon.e  = edge_cnt - 1;
      obs_q.push_back(mon);
    end
  end

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    recal = 1'b0;
    hold  = 1'b0;
    repeat (3) @(negedge sys_clk);
    exp_q.delete();
    obs_q.delete();
    sys_rst_n = 1'b1;
  endtask

  task automatic next_reading(output bit got, output rd_t o, output rd_t x);
    got = 1'b0;
    o = '{v: 16'd0, s: 1'b0, vs: 16'd0, ss: 1'b0, e: -1};
    x = '{v: 16'd0, s: 1'b0, vs: 16'd0, ss: 1'b0, e: -1};
    for (int i = 0; i < LIMIT && obs_q.size() == 0; i++) @(posedge sys_clk);
    if (obs_q.size() != 0) begin
      got = 1'b1;
      o = obs_q.pop_front();
      if (exp_q.size() != 0) x = exp_q.pop_front();
    end
  endtask

  task automatic wait_edge(input int n);
    for (int i = 0; i < LIMIT && edge_cnt < n; i++) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    ad_data = 8'd128;
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++; if (ad_clk !== 1'b0)    begin errors++; $display("FAIL reset_ad_clk got %b want 0", ad_clk); end
    checks++; if (volt !== 16'd0)     begin errors++; $display("FAIL reset_volt got %0d want 0", volt); end
    checks++; if (sign !== 1'b0)      begin errors++; $display("FAIL reset_sign got %b want 0", sign); end
    checks++; if (volt_vld !== 1'b0)  begin errors++; $display("FAIL reset_vld got %b want 0", volt_vld); end
    checks++; if (cal_done !== 1'b0)  begin errors++; $display("FAIL reset_cal_done got %b want 0", cal_done); end
    exp_q.delete();
    obs_q.delete();
    sys_rst_n = 1'b1;
  endtask

  task automatic test_clock_cal();
    bit got; rd_t o, x; logic want;
    ad_data = 8'd128;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      want = 1'((edge_cnt / 2) % 2);
      checks++;
      if (ad_clk !== want) begin errors++; $display("FAIL ad_clk_edge%0d got %b want %b", edge_cnt, ad_clk, want); end
    end
    wait_edge(63);
    checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL cal_done_before16 got %b want 0", cal_done); end
    @(negedge sys_clk);
    checks++; if (cal_done !== 1'b1) begin errors++; $display("FAIL cal_done_after16 got %b want 1", cal_done); end
    for (int i = 0; i < 3; i++) begin
      next_reading(got, o, x);
      checks++;
      if (!got || !rd_eq(o, x)) begin errors++; $display("FAIL cal128_model%0d got %s want %s", i, rd_str(o), rd_str(x)); end
      checks++;
      if (!got || o.v !== 16'd0 || o.s !== 1'b0 || o.e != 81 + 16 * i) begin
        errors++; $display("FAIL cal128_const%0d got %s want v=0 s=0 edge=%0d", i, rd_str(o), 81 + 16 * i);
      end
    end
  endtask

  task automatic test_levels();
    bit got; rd_t o, x;
    int lvl[4]    = '{255, 0, 129, 127};
    int want_v[4] = '{5000, 5000, 39, 39};
    int want_s[4] = '{0, 1, 0, 1};
    ad_data = 8'd128;
    do_reset();
    next_reading(got, o, x);
    checks++;
    if (!got || !rd_eq(o, x)) begin errors++; $display("FAIL levels_first got %s want %s", rd_str(o), rd_str(x)); end
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      ad_data = 8'(lvl[i]);
      for (int k = 0; k < 2; k++) begin
        next_reading(got, o, x);
        checks++;
        if (!got || !rd_eq(o, x)) begin errors++; $display("FAIL level%0d_model got %s want %s", lvl[i], rd_str(o), rd_str(x)); end
      end
      checks++;
      if (!got || o.v !== 16'(want_v[i]) || o.s !== 1'(want_s[i])) begin
        errors++; $display("FAIL level%0d_const got %s want v=%0d s=%0d", lvl[i], rd_str(o), want_v[i], want_s[i]);
      end
    end
  endtask

  task automatic test_saturate();
    bit got; rd_t o, x, last;
    ad_data = 8'd128;
    do_reset();
    next_reading(got, o, x);
    @(negedge sys_clk);
    ad_data = 8'd255;
    for (int k = 0; k < 2; k++) begin
      next_reading(got, o, x);
      checks++;
      if (!got || !rd_eq(o, x)) begin errors++; $display("FAIL sat_model got %s want %s", rd_str(o), rd_str(x)); end
    end
    checks++;
    if (!got || o.vs !== 16'd9999 || o.ss !== 1'b0 || o.v !== 16'd5000) begin
      errors++; $display("FAIL sat_const got %s want v=5000 vs=9999 ss=0", rd_str(o));
    end
    for (int c = 0; c < 48; c++) begin
      @(negedge sys_clk);
      ad_data = (((edge_cnt / PER) % 2) == 1) ? 8'd129 : 8'd128;
    end
    repeat (4) @(negedge sys_clk);
    last = '{v: 16'hffff, s: 1'b1, vs: 16'hffff, ss: 1'b1, e: -1};
    while (obs_q.size() != 0) begin
      next_reading(got, o, x);
      checks++;
      if (!got || !rd_eq(o, x)) begin errors++; $display("FAIL alt_model got %s want %s", rd_str(o), rd_str(x)); end
      last = o;
    end
    checks++;
    if (last.v !== 16'd0 || last.s !== 1'b0 || last.vs !== 16'd0 || last.ss !== 1'b0) begin
      errors++; $display("FAIL alt_const got %s want all zero", rd_str(last));
    end
  endtask

  task automatic test_hold();
    bit got; rd_t o, x;
    ad_data = 8'd128;
    do_reset();
    next_reading(got, o, x);
    @(negedge sys_clk);
    hold = 1'b1;
    ad_data = 8'd200;
    repeat (48) @(negedge sys_clk);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL hold_vld got %0d readings want 0", obs_q.size()); end
    checks++; if (volt !== 16'd0 || sign !== 1'b0) begin errors++; $display("FAIL hold_volt got %0d/%b want 0/0", volt, sign); end
    hold = 1'b0;
    next_reading(got, o, x);
    checks++;
    if (!got || !rd_eq(o, x)) begin errors++; $display("FAIL hold_release_model got %s want %s", rd_str(o), rd_str(x)); end
    checks++;
    if (!got || o.v !== 16'd2834 || o.s !== 1'b0) begin errors++; $display("FAIL hold_release_const got %s want v=2834 s=0", rd_str(o)); end
  endtask

  task automatic test_recal();
    bit got; rd_t o, x;
    ad_data = 8'd128;
    do_reset();
    next_reading(got, o, x);
    @(negedge sys_clk);
    ad_data = 8'd255;
    for (int k = 0; k < 2; k++) next_reading(got, o, x);
    checks++;
    if (!got || o.v !== 16'd5000) begin errors++; $display("FAIL recal_pre got %s want v=5000", rd_str(o)); end
    repeat (2) @(negedge sys_clk);
    ad_data = 8'd100;
    recal = 1'b1;
    @(negedge sys_clk);
    recal = 1'b0;
    checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL recal_cal_done got %b want 0", cal_done); end
    checks++; if (volt !== 16'd5000 || sign !== 1'b0) begin errors++; $display("FAIL recal_held got %0d/%b want 5000/0", volt, sign); end
    next_reading(got, o, x);
    checks++;
    if (!got || !rd_eq(o, x)) begin errors++; $display("FAIL recal_model got %s want %s", rd_str(o), rd_str(x)); end
    checks++;
    if (!got || o.v !== 16'd0 || o.s !== 1'b0 || cal_done !== 1'b1) begin
      errors++; $display("FAIL recal_zero100 got %s cal_done=%b want v=0 s=0 cal_done=1", rd_str(o), cal_done);
    end
    ad_data = 8'd128;
    do_reset();
    wait_edge(63);
    recal = 1'b1;
    @(negedge sys_clk);
    recal = 1'b0;
    checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL recal_on16 got %b want 0", cal_done); end
    wait_edge(127);
    checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL recal_restart_early got %b want 0", cal_done); end
    @(negedge sys_clk);
    checks++; if (cal_done !== 1'b1) begin errors++; $display("FAIL recal_restart_done got %b want 1", cal_done); end
    next_reading(got, o, x);
    checks++;
    if (!got || !rd_eq(o, x) || o.e != 145) begin errors++; $display("FAIL recal_restart_read got %s want %s (edge 145)", rd_str(o), rd_str(x)); end
  endtask

  task automatic test_async_reset();
    bit got; rd_t o, x;
    ad_data = 8'd128;
    do_reset();
    next_reading(got, o, x);
    @(negedge sys_clk);
    ad_data = 8'd255;
    next_reading(got, o, x);
    checks++;
    if (!got || o.v !== 16'd5000) begin errors++; $display("FAIL areset_pre got %s want v=5000", rd_str(o)); end
    repeat (3) @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({ad_clk, volt, sign, volt_vld, cal_done} !== 20'd0) begin
      errors++; $display("FAIL areset_dut got clk=%b v=%0d s=%b vld=%b cal=%b want all 0", ad_clk, volt, sign, volt_vld, cal_done);
    end
    checks++;
    if ({ad_clk_s, volt_s, sign_s, volt_vld_s, cal_done_s} !== 20'd0) begin
      errors++; $display("FAIL areset_sat got clk=%b v=%0d s=%b vld=%b cal=%b want all 0", ad_clk_s, volt_s, sign_s, volt_vld_s, cal_done_s);
    end
    @(negedge sys_clk);
    exp_q.delete();
    obs_q.delete();
    ad_data = 8'd128;
    sys_rst_n = 1'b1;
    next_reading(got, o, x);
    checks++;
    if (!got || !rd_eq(o, x) || o.e != 81 || o.v !== 16'd0) begin
      errors++; $display("FAIL areset_recal got %s want %s (edge 81 v=0)", rd_str(o), rd_str(x));
    end
  endtask

  task automatic test_random();
    bit got; rd_t o, x;
    logic [7:0] base;
    int n_read;
    base = 8'($urandom_range(0, 255));
    ad_data = base;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge sys_clk);
      checks++;
      if (cal_done !== m_cal) begin errors++; $display("FAIL rand_cal_done edge=%0d got %b want %b", edge_cnt, cal_done, m_cal); end
      if ($urandom_range(0, 23) == 0) base = 8'($urandom_range(0, 255));
      ad_data = base ^ 8'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) hold = ~hold;
      recal = ($urandom_range(0, 299) == 0);
    end
    @(negedge sys_clk);
    hold = 1'b0;
    recal = 1'b0;
    repeat (8) @(negedge sys_clk);
    n_read = 0;
    while (obs_q.size() != 0) begin
      next_reading(got, o, x);
      n_read++;
      checks++;
      if (!got || !rd_eq(o, x)) begin errors++; $display("FAIL rand_read%0d got %s want %s", n_read, rd_str(o), rd_str(x)); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rand_missing got %0d extra expected readings want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_clock_cal();
    test_levels();
    test_saturate();
    test_hold();
    test_recal();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
